// File: rtl/b_register.sv
// B operand register: loads the shared W bus when enabled and feeds the ALU B input continuously.
module b_register #(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] w_bus,
  output logic [WIDTH-1:0] alu_connection
);

  logic [WIDTH-1:0] b_reg;

  // Reset is active-low and asynchronous, so it overrides load on any edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b_reg <= RESET_VALUE;
    end else if (load) begin
      b_reg <= w_bus;
    end
  end

  assign alu_connection = b_reg;

endmodule

// File: tb/tb_b_register.sv
// Self-checking bench for b_register: vector table, directed corner sequences, and randomized model checks.
module tb_b_register;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'h00;

  logic         clk;
  logic         reset;
  logic         load;
  logic [W-1:0] w_bus;
  logic [W-1:0] alu_connection;

  int unsigned total;
  int unsigned bad;
  logic [W-1:0] model_q;

  typedef struct {
    logic         rst;
    logic         ld;
    logic [W-1:0] bus;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs [14];

  b_register #(
    .WIDTH(W),
    .RESET_VALUE(RV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .w_bus(w_bus),
    .alu_connection(alu_connection)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    load  = 1'b0;
    w_bus = '0;

    // Each vector is driven just after an edge and checked just after the following edge.
    vecs[0]  = '{1'b0, 1'b1, 8'h0A, 8'h00};
    vecs[1]  = '{1'b0, 1'b1, 8'hFF, 8'h00};
    vecs[2]  = '{1'b1, 1'b1, 8'h0A, 8'h0A};
    vecs[3]  = '{1'b1, 1'b0, 8'h55, 8'h0A};
    vecs[4]  = '{1'b1, 1'b0, 8'hA5, 8'h0A};
    vecs[5]  = '{1'b1, 1'b1, 8'hFF, 8'hFF};
    vecs[6]  = '{1'b1, 1'b1, 8'h3C, 8'h3C};
    vecs[7]  = '{1'b1, 1'b0, 8'h00, 8'h3C};
    vecs[8]  = '{1'b0, 1'b1, 8'hFF, 8'h00};
    vecs[9]  = '{1'b1, 1'b0, 8'hFF, 8'h00};
    vecs[10] = '{1'b1, 1'b1, 8'h81, 8'h81};
    vecs[11] = '{1'b1, 1'b1, 8'hxx, 8'hxx};
    vecs[12] = '{1'b1, 1'b1, 8'h5A, 8'h5A};
    vecs[13] = '{1'b1, 1'b1, 8'h00, 8'h00};

    @(posedge clk);
    #1;
    for (int i = 0; i < 14; i++) begin
      reset = vecs[i].rst;
      load  = vecs[i].ld;
      w_bus = vecs[i].bus;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), alu_connection, vecs[i].exp);
    end

    // Reset held low with load active: output pinned at reset value across edges.
    reset = 1'b0;
    load  = 1'b1;
    w_bus = 8'h0A;
    for (int i = 0; i < 4; i++) begin
      #4;
      check("rst_hold_mid", alu_connection, RV);
      @(posedge clk);
      #1;
      check("rst_hold_edge", alu_connection, RV);
    end

    // Release with load high: first load on the first edge after release.
    reset = 1'b1;
    #3;
    check("release_pre_edge", alu_connection, RV);
    @(posedge clk);
    #1;
    check("release_first_load", alu_connection, 8'h0A);

    // Hold with load low while the bus moves both at and between edges.
    load  = 1'b0;
    w_bus = 8'h55;
    for (int i = 0; i < 5; i++) begin
      #3;
      w_bus = 8'($urandom);
      @(posedge clk);
      #1;
      check("hold", alu_connection, 8'h0A);
    end

    // Back-to-back loads: each value appears one edge after being presented.
    load  = 1'b1;
    w_bus = 8'h0A;
    @(posedge clk);
    #1;
    check("step_0a", alu_connection, 8'h0A);
    w_bus = 8'hFF;
    #3;
    check("step_pre_ff", alu_connection, 8'h0A);
    @(posedge clk);
    #1;
    check("step_ff", alu_connection, 8'hFF);

    // Reload 0x0A, then pull reset between edges.
    w_bus = 8'h0A;
    @(posedge clk);
    #1;
    load = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    check("async_clear", alu_connection, RV);
    @(posedge clk);
    #1;
    reset = 1'b1;
    load  = 1'b1;
    w_bus = 8'h0A;
    #3;
    check("post_release_pre", alu_connection, RV);
    @(posedge clk);
    #1;
    check("post_release_reload", alu_connection, 8'h0A);

    // Randomized run against the reference value.
    model_q = 8'h0A;
    for (int i = 0; i < 300; i++) begin
      reset = ($urandom_range(0, 9) != 0);
      load  = $urandom_range(0, 1) != 0;
      w_bus = 8'($urandom);
      if (!reset) model_q = RV;
      #3;
      if (!reset) check("rnd_async", alu_connection, model_q);
      @(posedge clk);
      if (!reset)     model_q = RV;
      else if (load)  model_q = w_bus;
      #1;
      check("rnd", alu_connection, model_q);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
